mips_muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair for the MIPS core. It replaces the single-cycle combinational multiply/divide path with an iterative shift-add multiplier and restoring divider, plus a busy/done handshake so the core can stall MFHI/MFLO. It sits beside the main ALU and is driven by the core's decode stage.

---
 rtl/mips_muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the MIPS HI/LO pair.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle one.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clock_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state | meaning
  // IDLE  | waiting for start; MTHI/MTLO complete here
  // MUL   | one shift-add step per cycle, WIDTH steps
  // DIV   | one restoring quotient bit per cycle, WIDTH steps
  // FIX   | sign correction, write hi/lo, pulse done

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;
  logic             neg_res;
  logic             neg_rem;
  logic             div_op;
  logic             div_zero;

  logic             signed_op;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    rs_mag    = (signed_op && rs[WIDTH-1]) ? -rs : rs;
    rt_mag    = (signed_op && rt[WIDTH-1]) ? -rt : rt;

    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);

    // the partial remainder is always below the divisor, so a WIDTH-bit subtract suffices
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb});
    div_sub   = div_shift[WIDTH-1:0] - opb;

    prod_raw  = {acc_hi, acc_lo};
    prod_neg  = -prod_raw;

    if (div_op) begin
      fix_lo = div_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
      fix_hi = neg_rem ? -acc_hi : acc_hi;
    end else begin
      {fix_hi, fix_lo} = neg_res ? prod_neg : prod_raw;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;

  always_comb begin
    if (op == OP_MULT)
      fast_prod = {{WIDTH{rs[WIDTH-1]}}, rs} * {{WIDTH{rt[WIDTH-1]}}, rt};
    else
      fast_prod = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_op   <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (clock_enable) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: hi <= rs;
              OP_MTLO: lo <= rs;
              OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                {hi, lo} <= fast_prod;
                done     <= 1'b1;
`else
                state    <= S_MUL;
                busy     <= 1'b1;
                cnt      <= CW'(WIDTH - 1);
                acc_hi   <= '0;
                acc_lo   <= rt_mag;
                opb      <= rs_mag;
                neg_res  <= signed_op & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                neg_rem  <= 1'b0;
                div_op   <= 1'b0;
                div_zero <= 1'b0;
`endif
              end
              OP_DIV, OP_DIVU: begin
                state    <= S_DIV;
                busy     <= 1'b1;
                cnt      <= CW'(WIDTH - 1);
                acc_hi   <= '0;
                acc_lo   <= rs_mag;
                opb      <= rt_mag;
                neg_res  <= signed_op & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                neg_rem  <= signed_op & rs[WIDTH-1];
                div_op   <= 1'b1;
                div_zero <= (rt == '0);
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_DIV: begin
          if (div_ge) begin
            acc_hi <= div_sub;
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: stimulus pushes expected hi/lo and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_mips_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int DIV_DONE = W + 2;
  localparam int MUL_DONE = FAST ? 1 : W + 2;

  logic         clk = 1'b0;
  logic         reset, clock_enable, start;
  logic [2:0]   op;
  logic [W-1:0] rs, rt;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clock_enable(clock_enable), .start(start),
    .op(op), .rs(rs), .rt(rt), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected done=0 at tb cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        check($sformatf("op%0d_hi", e.id), 64'(hi), 64'(e.hi));
        check($sformatf("op%0d_lo", e.id), 64'(lo), 64'(e.lo));
        check($sformatf("op%0d_done_cycle", e.id), 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    tick();
    start = 1'b0;
  endtask

  // pushes expectation, issues, and leaves the bench inside the done cycle
  task automatic run_op(input int id, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input int stall);
    exp_t e;
    int   dc;
    dc = (o <= 3'd1) ? MUL_DONE : DIV_DONE;
    issue(o, a, b);
    e.hi  = eh;
    e.lo  = el;
    e.cyc = cyc + dc - 1 + stall;
    e.id  = id;
    sb.push_back(e);
    repeat (dc - 1 + stall) tick();
  endtask

  initial begin
    int           bad;
    logic [W-1:0] hold_hi, hold_lo;
    exp_t         e;

    reset = 1'b1; clock_enable = 1'b1; start = 1'b0; op = '0; rs = '0; rt = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);

    issue(3'd4, 32'hA5A5A5A5, 32'h0);
    check("mthi_hi", 64'(hi), 64'hA5A5A5A5);
    check("mthi_busy", 64'(busy), 64'd0);
    issue(3'd5, 32'h5A5A5A5A, 32'h0);
    check("mtlo_lo", 64'(lo), 64'h5A5A5A5A);
    check("mtlo_hi_kept", 64'(hi), 64'hA5A5A5A5);

    issue(3'd6, 32'h12345678, 32'h1);
    tick();
    check("reserved_hi", 64'(hi), 64'hA5A5A5A5);
    check("reserved_lo", 64'(lo), 64'h5A5A5A5A);
    check("reserved_busy", 64'(busy), 64'd0);

    if (!FAST) begin
      issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      e.hi = 32'hFFFFFFFE; e.lo = 32'h00000001; e.cyc = cyc + W + 1; e.id = 1;
      sb.push_back(e);
      bad = 0;
      for (int j = 1; j <= W + 1; j++) begin
        if (busy !== 1'b1 || hi !== 32'hA5A5A5A5) bad++;
        tick();
      end
      check("multu_busy_window", 64'(bad), 64'd0);
      check("multu_busy_clear", 64'(busy), 64'd0);
    end else begin
      run_op(1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    end

    run_op(2,  3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    run_op(3,  3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
    run_op(4,  3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op(5,  3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
    run_op(6,  3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 0);
    run_op(7,  3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 0);
    run_op(8,  3'd2, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 0);
    run_op(9,  3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    run_op(10, 3'd2, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 0);

    if (!FAST) begin
      issue(3'd0, 32'h00010000, 32'h00010000);
      e.hi = 32'h1; e.lo = 32'h0; e.cyc = cyc + W + 1; e.id = 11;
      sb.push_back(e);
      hold_hi = hi;
      hold_lo = lo;
      tick();
      issue(3'd5, 32'h00001111, 32'h0);
      check("mtlo_ignored_lo", 64'(lo), 64'(hold_lo));
      issue(3'd2, 32'd100, 32'd7);
      check("div_ignored_hi", 64'(hi), 64'(hold_hi));
      check("div_ignored_busy", 64'(busy), 64'd1);
      repeat (W + 2 - 4) tick();
    end

    issue(3'd2, 32'd100, 32'd7);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    repeat (W + 8) tick();

    issue(3'd3, 32'd100, 32'd7);
    e.hi = 32'd2; e.lo = 32'd14; e.cyc = cyc + 38; e.id = 12;
    sb.push_back(e);
    repeat (4) tick();
    clock_enable = 1'b0;
    hold_hi = hi;
    hold_lo = lo;
    bad = 0;
    repeat (5) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0 || hi !== hold_hi || lo !== hold_lo) bad++;
    end
    clock_enable = 1'b1;
    check("stall_hold", 64'(bad), 64'd0);
    repeat (29) tick();

    bad = 0;
    while (sb.size() != 0 && bad < 100) begin
      tick();
      bad++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
